alu_cond_wb: RTL and testbench
==============================

# alu_cond_wb

Condition-check and writeback stage directly downstream of the 32-bit ALU. Each cycle it can accept one ALU result with its NZCV flags, evaluate the instruction's 4-bit condition code against the architectural flags register, and conditionally update that register. It then presents the result to the register-file writeback port through a one-entry valid/ready pipeline register.

## Interface
Parameters:
- `DW`, 32, data width of the result path (must match ALU `Result`)
- `RW`, 4, register-address width
- `CW`, 16, width of statistics counters (used only with `ALU_COND_STATS_EN`)

Ports:
- `clk`, in, 1, single clock; all state updates on rising edge
- `reset`, in, 1, synchronous, active-high
- `in_valid`, in, 1, upstream holds a valid ALU result
- `in_ready`, out, 1, stage can accept this cycle
- `result`, in, DW, ALU `Result`
- `alu_flags`, in, 4, ALU flags `{N,Z,C,V}`
- `cond`, in, 4, ARM-style condition code
- `flag_write`, in, 2, bit1 updates N,Z; bit0 updates C,V
- `rd`, in, RW, destination register
- `reg_write`, in, 1, instruction wants a register write
- `out_valid`, out, 1, writeback entry valid
- `out_ready`, in, 1, register file consumes the entry
- `wb_data`, out, DW, registered result
- `wb_rd`, out, RW, registered destination
- `wb_en`, out, 1, `reg_write` AND condition passed
- `flags`, out, 4, architectural `{N,Z,C,V}`
- `exec_cnt`, out, CW, executed count (only with `ALU_COND_STATS_EN`)
- `skip_cnt`, out, CW, skipped count (only with `ALU_COND_STATS_EN`)

## Operation
- Condition pass is evaluated combinationally from the current `flags` register, never from `alu_flags`.
- Condition codes: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1; F treated as AL.
- Accept = `in_valid & in_ready`. On accept:
  - `wb_data`←`result`, `wb_rd`←`rd`, `wb_en`←`reg_write & pass`, `out_valid`←1.
  - If pass and `flag_write[1]`: N,Z ← `alu_flags[3:2]`. If pass and `flag_write[0]`: C,V ← `alu_flags[1:0]`.
  - A failed condition changes no flags. It still produces an output entry with `wb_en`=0, which keeps the retire order visible.
- No accept and `out_ready`: `out_valid`←0; data fields hold their last values.
- States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with `out_ready`.
  - FULL→EMPTY on `out_ready` without accept.
  - FULL holds while `out_ready`=0.

## Timing
- `in_ready` = `~out_valid | out_ready`. This is combinational from `out_ready`; there is no other combinational in→out path.
- Latency: one cycle from accept to `out_valid`.
- `flags` updates on the same edge that registers the entry.
- Back-to-back: an instruction accepted at cycle n+1 evaluates against the flags written by the instruction accepted at cycle n.
- While `out_valid & ~out_ready`, the outputs `wb_data`/`wb_rd`/`wb_en` must remain stable. `flags` must not change.
- Reset values: `out_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_en`=0, `flags`=4'b0000, counters 0.
- Reset mid-operation discards any held entry. Reset takes priority over a simultaneous accept.

## Configuration
- `ALU_COND_STATS_EN` defined: `exec_cnt` increments on each accept with pass, and `skip_cnt` increments on each accept with fail. Both saturate at all-ones and are cleared by reset.
- Not defined: counters and their ports are absent. All other behaviour is identical.

## Test plan
- Reset, then accept `result`=0x0000_0005, `cond`=E, `flag_write`=2'b11, `alu_flags`=4'b0010, `rd`=3, `reg_write`=1. Next cycle: `out_valid`=1, `wb_data`=5, `wb_rd`=3, `wb_en`=1, `flags`=0010.
- Flags Z=1, then send `cond`=1 (NE), `reg_write`=1, `flag_write`=2'b11, `alu_flags`=4'b1000. Required: `wb_en`=0, `flags` unchanged at 0100, `skip_cnt`=1.
- Back-to-back: a CMP-type entry (`flag_write`=11, `alu_flags`=0100, `reg_write`=0), then in the next cycle `cond`=0 (EQ). The second entry must have `wb_en`=1.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1. Required: `in_ready`=0, outputs and `flags` stable. Raise `out_ready`: one transfer completes and the next entry is accepted in the same cycle.
- Assert `reset` while FULL and `in_valid`=1. Next cycle: `out_valid`=0, `flags`=0000, counters 0.
- With stats enabled, preload `skip_cnt` to 0xFFFF via 65535 skips. One more skip keeps it at 0xFFFF.

Source files
------------

// File: rtl/alu_cond_wb.sv
// alu_cond_wb: condition check, NZCV flags update and one-entry writeback register; stats counters with ALU_COND_STATS_EN.
// Latency 1 cycle from accept; in_ready = ~out_valid | out_ready, so the entry holds while out_ready is low.
module alu_cond_wb #(
    parameter int DW = 32,
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] result,
    input  logic [3:0]    alu_flags,
    input  logic [3:0]    cond,
    input  logic [1:0]    flag_write,
    input  logic [RW-1:0] rd,
    input  logic          reg_write,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rd,
    output logic          wb_en,
    output logic [3:0]    flags
`ifdef ALU_COND_STATS_EN
    ,
    output logic [CW-1:0] exec_cnt,
    output logic [CW-1:0] skip_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_t;

    state_t state;
    logic   accept;
    logic   pass;
    logic   fn, fz, fc, fv;

    assign fn = flags[3];
    assign fz = flags[2];
    assign fc = flags[1];
    assign fv = flags[0];

    assign out_valid = (state == FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    // Evaluated against the architectural register, so back-to-back entries see the previous update.
    always_comb begin
        pass = 1'b1;
        case (cond_t'(cond))
            CC_EQ:   pass = fz;
            CC_NE:   pass = ~fz;
            CC_CS:   pass = fc;
            CC_CC:   pass = ~fc;
            CC_MI:   pass = fn;
            CC_PL:   pass = ~fn;
            CC_VS:   pass = fv;
            CC_VC:   pass = ~fv;
            CC_HI:   pass = fc & ~fz;
            CC_LS:   pass = ~fc | fz;
            CC_GE:   pass = (fn == fv);
            CC_LT:   pass = (fn != fv);
            CC_GT:   pass = ~fz & (fn == fv);
            CC_LE:   pass = fz | (fn != fv);
            default: pass = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            wb_data <= '0;
            wb_rd   <= '0;
            wb_en   <= 1'b0;
            flags   <= 4'b0000;
        end else begin
            if (accept) begin
                wb_data <= result;
                wb_rd   <= rd;
                wb_en   <= reg_write & pass;
                if (pass && flag_write[1]) flags[3:2] <= alu_flags[3:2];
                if (pass && flag_write[0]) flags[1:0] <= alu_flags[1:0];
            end
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (!accept && out_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef ALU_COND_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (accept) begin
            if (pass && exec_cnt != {CW{1'b1}}) exec_cnt <= exec_cnt + 1'b1;
            if (!pass && skip_cnt != {CW{1'b1}}) skip_cnt <= skip_cnt + 1'b1;
        end
    end
`else
    // Counter width has no consumer when statistics are compiled out.
    wire [CW-1:0] cw_unused = '0;
`endif

endmodule

// File: tb/tb_alu_cond_wb.sv
// Randomized self-checking bench for alu_cond_wb against a queue-free behavioural model of the stage.
module tb_alu_cond_wb;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] result;
    logic [3:0]    alu_flags;
    logic [3:0]    cond;
    logic [1:0]    flag_write;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_en;
    logic [3:0]    flags;
`ifdef ALU_COND_STATS_EN
    logic [CW-1:0] exec_cnt;
    logic [CW-1:0] skip_cnt;
`endif

    always #5 clk = ~clk;

    alu_cond_wb #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .alu_flags(alu_flags), .cond(cond), .flag_write(flag_write),
        .rd(rd), .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en), .flags(flags)
`ifdef ALU_COND_STATS_EN
        , .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference state: the entry the register file should see, and the NZCV register.
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_rd;
    bit            m_en;
    logic [3:0]    m_flags;
    int            m_exec;
    int            m_skip;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Even codes name a base predicate, odd codes invert it; E and F always execute.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("wb_data", wb_data, m_data);
        check("wb_rd", wb_rd, m_rd);
        check("wb_en", wb_en, m_en);
        check("flags", flags, m_flags);
`ifdef ALU_COND_STATS_EN
        check("exec_cnt", exec_cnt, m_exec);
        check("skip_cnt", skip_cnt, m_skip);
`endif
    endtask

    // One clock with the currently driven inputs; model advances on the edge, outputs checked 1 time unit later.
    task automatic step();
        bit acc, p;
        @(negedge clk);
        check("in_ready", in_ready, !m_valid || out_ready);
        acc = in_valid && (!m_valid || out_ready);
        p   = ref_pass(cond, m_flags);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_data = '0; m_rd = '0; m_en = 0; m_flags = 4'b0000;
            m_exec = 0; m_skip = 0;
        end else if (acc) begin
            m_valid = 1;
            m_data  = result;
            m_rd    = rd;
            m_en    = reg_write && p;
            if (p && flag_write[1]) m_flags[3:2] = alu_flags[3:2];
            if (p && flag_write[0]) m_flags[1:0] = alu_flags[1:0];
            if (p) m_exec = (m_exec == CMAX) ? CMAX : m_exec + 1;
            else   m_skip = (m_skip == CMAX) ? CMAX : m_skip + 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] r, input logic [3:0] c,
                         input logic [1:0] fw, input logic [3:0] af,
                         input logic [RW-1:0] d, input bit rw);
        in_valid = v; result = r; cond = c; flag_write = fw; alu_flags = af; rd = d; reg_write = rw;
    endtask

    logic [DW-1:0] held_data;
    logic [3:0]    held_flags;

    initial begin
        m_valid = 0; m_data = '0; m_rd = '0; m_en = 0; m_flags = '0; m_exec = 0; m_skip = 0;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(0, '0, 4'h0, 2'b00, 4'h0, '0, 0);
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_flags", flags, 4'b0000);
        reset = 1'b0;

        // First entry under AL updates all flags and writes r3.
        drive(1, 32'h0000_0005, 4'hE, 2'b11, 4'b0010, 4'd3, 1);
        step();
        drive(0, '0, 4'h0, 2'b00, 4'h0, '0, 0);
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_wb_data", wb_data, 32'd5);
        check("t1_wb_rd", wb_rd, 4'd3);
        check("t1_wb_en", wb_en, 1'b1);
        check("t1_flags", flags, 4'b0010);

        // Set Z, then NE fails: no write, flags unchanged.
        drive(1, 32'h11, 4'hE, 2'b11, 4'b0100, 4'd1, 0);
        step();
        drive(1, 32'h22, 4'h1, 2'b11, 4'b1000, 4'd2, 1);
        step();
        check("t2_wb_en", wb_en, 1'b0);
        check("t2_flags", flags, 4'b0100);
`ifdef ALU_COND_STATS_EN
        check("t2_skip_cnt", skip_cnt, 16'd1);
`endif

        // CMP then dependent EQ on the very next cycle.
        drive(1, 32'h33, 4'hE, 2'b11, 4'b0100, 4'd0, 0);
        step();
        drive(1, 32'h44, 4'h0, 2'b00, 4'b0000, 4'd7, 1);
        step();
        check("t3_wb_en", wb_en, 1'b1);
        check("t3_wb_data", wb_data, 32'h44);

        // Backpressure for three cycles: stage holds, then transfers and accepts in one edge.
        out_ready = 1'b0;
        drive(1, 32'h55, 4'hE, 2'b11, 4'b1111, 4'd9, 1);
        held_data  = wb_data;
        held_flags = flags;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_in_ready", in_ready, 1'b0);
            check("t4_hold_data", wb_data, held_data);
            check("t4_hold_flags", flags, held_flags);
        end
        out_ready = 1'b1;
        step();
        check("t4_release_valid", out_valid, 1'b1);
        check("t4_release_data", wb_data, 32'h55);
        check("t4_release_flags", flags, 4'b1111);

        // Reset while full with a pending accept.
        out_ready = 1'b0;
        drive(1, 32'h66, 4'hE, 2'b11, 4'b1010, 4'd4, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_flags", flags, 4'b0000);
`ifdef ALU_COND_STATS_EN
        check("t5_exec_cnt", exec_cnt, 16'd0);
        check("t5_skip_cnt", skip_cnt, 16'd0);
`endif

        // Randomized traffic with random backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, $urandom, 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  RW'($urandom_range(0, (1 << RW) - 1)), $urandom_range(0, 1) == 1);
            step();
        end
        reset = 1'b0;

`ifdef ALU_COND_STATS_EN
        // Saturate skip_cnt: EQ fails with Z clear after reset and no flags change.
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1, 32'h77, 4'h0, 2'b11, 4'b0100, 4'd5, 1);
        for (int i = 0; i < 65535; i++) step();
        check("sat_skip_preload", skip_cnt, 16'hFFFF);
        step();
        check("sat_skip_hold", skip_cnt, 16'hFFFF);
        check("sat_exec_zero", exec_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
